// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter feeding one shared data register, with bounded burst locking.
// The stored word is tagged with its source, and a one-cycle valid strobe marks each load.
module shared_reg_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MAX_HOLD = 4,
    localparam int unsigned IW      = $clog2(NUM_REQ),
    localparam int unsigned HW      = $clog2(MAX_HOLD + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]       grant,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic [IW-1:0]            q_src
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      hold_q, hold_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [HW-1:0]      hcnt_q, hcnt_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [IW-1:0]      q_src_q, q_src_d;

    logic [WIDTH-1:0]   words [NUM_REQ];
    logic [NUM_REQ-1:0] cand;
    logic [IW-1:0]      start;
    logic [IW-1:0]      hold_nxt;
    logic [IW-1:0]      win;
    logic [IW-1:0]      cand_idx;
    logic               found;
    logic               rel;
    int                 idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = wdata[g*WIDTH +: WIDTH];
    end

    assign hold_nxt = (hold_q == IW'(NUM_REQ - 1)) ? '0 : hold_q + 1'b1;

    // While granted, the holder is masked and the scan starts just past it.
    always_comb begin
        cand     = req;
        start    = ptr_q;
        found    = 1'b0;
        win      = '0;
        cand_idx = '0;
        idx      = 0;
        if (state_q == StGrant) begin
            cand  = req & ~grant_q;
            start = hold_nxt;
        end
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            idx = int'(start) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            cand_idx = IW'(idx);
            if (!found && cand[cand_idx]) begin
                found = 1'b1;
                win   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        hcnt_d    = hcnt_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        q_src_d   = q_src_q;
        rel       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = NUM_REQ'(1) << win;
                    hold_d  = win;
                    hcnt_d  = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                rel = 1'b1;
                if (req[hold_q]) begin
                    q_d       = words[hold_q];
                    q_src_d   = hold_q;
                    q_valid_d = 1'b1;
                    hcnt_d    = hcnt_q + 1'b1;
                    if (lock[hold_q] && (int'(hcnt_q) + 1 < int'(MAX_HOLD))) begin
                        rel = 1'b0;
                    end
                end
                if (rel) begin
                    ptr_d = hold_nxt;
                    if (found) begin
                        grant_d = NUM_REQ'(1) << win;
                        hold_d  = win;
                        hcnt_d  = '0;
                    end else begin
                        grant_d = '0;
                        hcnt_d  = '0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            hold_q    <= '0;
            ptr_q     <= '0;
            hcnt_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            q_src_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            hcnt_q    <= hcnt_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            q_src_q   <= q_src_d;
        end
    end

    assign grant   = grant_q;
    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign q_src   = q_src_q;

endmodule
